fft_sample_bridge: RTL
======================

# fft_sample_bridge

Parametrised successor to the FFT AXI sample bridge. Loads one frame of N samples from a valid/ready write stream into the FFT sample RAM, signals the core, waits for calculation end, then streams the N results back out of the RAM on a valid/ready read stream. Compared with the previous bridge, it adds:
- parametric sample, data and address widths;
- a per-frame latched sample count;
- correct handling of a 1-cycle RAM read latency with a 2-entry output buffer (full throughput under back-pressure);
- a last-beat flag;
- optional bit-reversed unload.

## Interface
Parameters:
- DATA_WIDTH, 32, width of a RAM result word (complex re/im) and of o_ARDATA
- SAMPLE_WIDTH, 16, width of an input sample written to RAM
- ADDR_WIDTH, 12, RAM index width; maximum frame length 2^ADDR_WIDTH

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_SAMPLES_NUMBER  in  ADDR_WIDTH+1  frame length N; 0 = no frame; values above 2^ADDR_WIDTH saturate to 2^ADDR_WIDTH
- i_AWDATA  in  SAMPLE_WIDTH  input sample
- i_AWVALID  in  1  input sample valid
- o_AWREADY  out  1  bridge accepts a sample
- o_WRITE_ram  out  1  RAM write strobe
- o_SAMPLE_ram  out  SAMPLE_WIDTH  RAM write data
- o_READ_ram  out  1  RAM read strobe; data returns on i_DATA_FROM_RAM one cycle later
- o_SAMPLE_INDEX_ram  out  ADDR_WIDTH  RAM address for the write or read
- i_DATA_FROM_RAM  in  DATA_WIDTH  RAM read data
- o_DATA_LOADED  out  1  one-cycle pulse: frame fully written
- i_CALC_END  in  1  FFT core finished; sampled only in WAIT_CALC
- o_ARDATA  out  DATA_WIDTH  output result
- o_ARVALID  out  1  output result valid
- i_ARREADY  in  1  downstream accepts a result
- o_ARLAST  out  1  high with the beat for index N-1

## Operation
- **States:** IDLE, LOAD, WAIT_CALC, UNLOAD.
- **IDLE:**
  - o_AWREADY = (i_SAMPLES_NUMBER != 0).
  - On a handshake (i_AWVALID && o_AWREADY): latch N, write the sample at index 0, go to LOAD with the write counter at 1.
  - If N == 1, go directly to WAIT_CALC.
- **LOAD:**
  - o_AWREADY = 1.
  - Each handshake drives o_WRITE_ram=1, o_SAMPLE_ram=i_AWDATA and o_SAMPLE_INDEX_ram=write counter combinationally in the same cycle, then increments the counter.
  - Cycles with no handshake produce no write and no increment.
  - The handshake at index N-1 moves the FSM to WAIT_CALC.
- **WAIT_CALC:**
  - o_AWREADY = 0.
  - o_DATA_LOADED pulses high in the first WAIT_CALC cycle only.
  - i_CALC_END = 1 moves the FSM to UNLOAD; i_ARREADY is not a condition.
  - i_CALC_END is ignored in all other states.
- **UNLOAD:**
  - Issue a read (o_READ_ram=1, o_SAMPLE_INDEX_ram=read address, read counter +1) whenever both hold: read counter < N, and buffer occupancy + reads in flight < 2.
  - Returned data enters a 2-entry FIFO; its head drives o_ARDATA and o_ARVALID.
  - A beat transfers on o_ARVALID && i_ARREADY.
  - o_ARLAST = 1 on the head beat that carries index N-1.
  - Acceptance of the last beat returns the FSM to IDLE with the counters and buffer cleared.
- **Counters:** ADDR_WIDTH+1 bits wide, so N = 2^ADDR_WIDTH does not wrap. Changes to i_SAMPLES_NUMBER after the frame starts are ignored.
- **Read/write exclusion:** o_WRITE_ram and o_READ_ram are never high together. o_SAMPLE_INDEX_ram is 0 when neither strobe is high.

## Timing
- **Reset:** every output is 0 while i_rstn = 0, and the FSM is in IDLE. Reset mid-frame discards the frame, the buffer and in-flight reads. The first handshake after reset writes index 0.
- **Load throughput:** 1 sample/cycle; zero latency from handshake to RAM write.
- **o_DATA_LOADED:** registered, asserted the cycle after the final write handshake.
- **Unload start:** the UNLOAD entry cycle t issues read 0; o_ARVALID first rises at t+2.
- **Unload throughput:** with i_ARREADY held at 1, beats are back-to-back, and the last beat completes at t+N+1.
- **Back-pressure:**
  - While o_ARVALID && !i_ARREADY, o_ARDATA and o_ARLAST are held stable.
  - No beat is lost or duplicated.
  - At most 2 reads are outstanding or buffered.
- **Return to IDLE:** in the cycle after the last-beat acceptance, o_AWREADY may be 1 again.

## Configuration
- BRIDGE_BITREV_EN defined:
  - At frame start, also latch k = log2(N) when N is a power of two.
  - The UNLOAD read address is the read counter with its low k bits reversed.
  - If N is not a power of two, addressing is linear for that frame.
  - Load addressing is always linear.
- BRIDGE_BITREV_EN undefined: the UNLOAD address always equals the read counter; no bit-reverse logic is present.

## Test plan
- N=8, i_AWVALID held 1, data 0x10..0x17 -> 8 writes at indices 0..7; o_DATA_LOADED pulses 1 cycle after the 8th write; o_AWREADY=0 in WAIT_CALC.
- N=8, i_AWVALID pattern 1,0,0,1,... -> exactly 8 writes with consecutive indices; no write and no index change on idle cycles.
- After load, i_CALC_END=1, i_ARREADY=1, RAM returns addr*3 -> 8 beats 0,3,...,21 back-to-back; first o_ARVALID 2 cycles after UNLOAD entry; o_ARLAST only on the beat with value 21; FSM back to IDLE.
- Same as previous, but with i_ARREADY toggling 1,0,1,0 and a random stall of 5 cycles -> identical beat sequence; data stable during stalls; never more than 2 reads outstanding.
- i_rstn low for 1 cycle mid-UNLOAD (after beat 3) -> all outputs 0 immediately; next frame N=4 writes indices 0..3 and unloads cleanly.
- BRIDGE_BITREV_EN, N=8 -> read addresses 0,4,2,6,1,5,3,7; N=6 -> read addresses 0..5 linear.

Source files
------------

// File: rtl/fft_sample_bridge_if.sv
// -----------------------------------------------------------------------------
// fft_sample_bridge_if
// Bundles every non-clock signal of fft_sample_bridge: the sample write stream
// (AW*), the FFT sample RAM port (*_ram, i_DATA_FROM_RAM), the core handshake
// (o_DATA_LOADED / i_CALC_END) and the result read stream (AR*).
//   slave  : seen from the bridge (drives o_*, receives i_*)
//   master : seen from the environment (drives i_*, receives o_*)
// -----------------------------------------------------------------------------
interface fft_sample_bridge_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int SAMPLE_WIDTH = 16,
   parameter int ADDR_WIDTH   = 12
);
   logic [ADDR_WIDTH:0]     i_SAMPLES_NUMBER;
   logic [SAMPLE_WIDTH-1:0] i_AWDATA;
   logic                    i_AWVALID;
   logic                    o_AWREADY;
   logic                    o_WRITE_ram;
   logic [SAMPLE_WIDTH-1:0] o_SAMPLE_ram;
   logic                    o_READ_ram;
   logic [ADDR_WIDTH-1:0]   o_SAMPLE_INDEX_ram;
   logic [DATA_WIDTH-1:0]   i_DATA_FROM_RAM;
   logic                    o_DATA_LOADED;
   logic                    i_CALC_END;
   logic [DATA_WIDTH-1:0]   o_ARDATA;
   logic                    o_ARVALID;
   logic                    i_ARREADY;
   logic                    o_ARLAST;

   modport slave (
      input  i_SAMPLES_NUMBER, i_AWDATA, i_AWVALID, i_DATA_FROM_RAM, i_CALC_END, i_ARREADY,
      output o_AWREADY, o_WRITE_ram, o_SAMPLE_ram, o_READ_ram, o_SAMPLE_INDEX_ram,
             o_DATA_LOADED, o_ARDATA, o_ARVALID, o_ARLAST
   );

   modport master (
      output i_SAMPLES_NUMBER, i_AWDATA, i_AWVALID, i_DATA_FROM_RAM, i_CALC_END, i_ARREADY,
      input  o_AWREADY, o_WRITE_ram, o_SAMPLE_ram, o_READ_ram, o_SAMPLE_INDEX_ram,
             o_DATA_LOADED, o_ARDATA, o_ARVALID, o_ARLAST
   );
endinterface

// File: rtl/fft_sample_bridge.sv
// -----------------------------------------------------------------------------
// fft_sample_bridge
// Loads one frame of N samples from the AW stream into the FFT sample RAM,
// pulses o_DATA_LOADED, waits for i_CALC_END, then streams the N results back
// out of the RAM on the AR stream (o_ARLAST on index N-1).
// Ports:
//   i_clk  : clock, rising edge
//   i_rstn : asynchronous active-low reset; all outputs are 0 while low
//   bus    : fft_sample_bridge_if.slave (AW stream, RAM port, core handshake,
//            AR stream)
// Configuration macro:
//   BRIDGE_BITREV_EN : when defined, unload addresses of power-of-two frames
//                      are the read counter with its low log2(N) bits reversed.
// -----------------------------------------------------------------------------
module fft_sample_bridge #(
   parameter int DATA_WIDTH   = 32,
   parameter int SAMPLE_WIDTH = 16,
   parameter int ADDR_WIDTH   = 12
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   fft_sample_bridge_if.slave bus
);
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [CW-1:0] N_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_CALC, S_UNLOAD} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         n_q, n_d;
   logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]         out_cnt_q, out_cnt_d;
   logic                  loaded_q, loaded_d;
   logic                  inflight_q, inflight_d;
   logic [1:0]            fifo_cnt_q, fifo_cnt_d;
   logic                  fifo_wp_q, fifo_wp_d;
   logic                  fifo_rp_q, fifo_rp_d;
   logic [DATA_WIDTH-1:0] fifo_mem_q [2];

   logic [CW-1:0]         n_sat, n_last;
   logic                  awready, start, wr_en, rd_en, push, pop, head_vld, frame_done;
   logic [ADDR_WIDTH-1:0] wr_idx, rd_addr;
   logic [1:0]            occ_after;

   assign n_sat    = (bus.i_SAMPLES_NUMBER > N_MAX) ? N_MAX : bus.i_SAMPLES_NUMBER;
   assign n_last   = n_q - ONE;
   assign head_vld = (fifo_cnt_q != 2'd0);

`ifdef BRIDGE_BITREV_EN
   localparam int KW = $clog2(ADDR_WIDTH + 1);

   logic [KW-1:0] k_q, k_d;
   logic          pow2_q, pow2_d;

   function automatic logic [KW-1:0] log2_pow2(input logic [CW-1:0] n);
      logic [KW-1:0] k;
      k = '0;
      for (int i = 0; i < CW; i++)
         if (n[i]) k = KW'(i);
      return k;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] bit_reverse(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [KW-1:0] k);
      logic [ADDR_WIDTH-1:0] r;
      r = a;
      for (int i = 0; i < ADDR_WIDTH; i++)
         for (int j = 0; j < ADDR_WIDTH; j++)
            if ((i < int'(k)) && (j == int'(k) - 1 - i)) r[i] = a[j];
      return r;
   endfunction

   always_comb begin
      k_d    = k_q;
      pow2_d = pow2_q;
      if (start) begin
         pow2_d = ((n_sat & (n_sat - ONE)) == '0);
         k_d    = log2_pow2(n_sat);
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         k_q    <= '0;
         pow2_q <= 1'b0;
      end else begin
         k_q    <= k_d;
         pow2_q <= pow2_d;
      end
   end

   assign rd_addr = pow2_q ? bit_reverse(rd_cnt_q[ADDR_WIDTH-1:0], k_q)
                           : rd_cnt_q[ADDR_WIDTH-1:0];
`else
   assign rd_addr = rd_cnt_q[ADDR_WIDTH-1:0];
`endif

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      out_cnt_d  = out_cnt_q;
      loaded_d   = 1'b0;
      inflight_d = 1'b0;
      fifo_cnt_d = fifo_cnt_q;
      fifo_wp_d  = fifo_wp_q;
      fifo_rp_d  = fifo_rp_q;
      awready    = 1'b0;
      start      = 1'b0;
      wr_en      = 1'b0;
      wr_idx     = '0;
      rd_en      = 1'b0;
      pop        = 1'b0;
      push       = inflight_q;
      occ_after  = 2'd0;
      frame_done = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Gated by reset so the combinational ready is also 0 in reset.
            awready = i_rstn && (bus.i_SAMPLES_NUMBER != '0);
            if (awready && bus.i_AWVALID) begin
               start    = 1'b1;
               wr_en    = 1'b1;
               n_d      = n_sat;
               wr_cnt_d = ONE;
               if (n_sat == ONE) begin
                  state_d  = S_WAIT_CALC;
                  loaded_d = 1'b1;
               end else begin
                  state_d  = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            awready = 1'b1;
            if (bus.i_AWVALID) begin
               wr_en    = 1'b1;
               wr_idx   = wr_cnt_q[ADDR_WIDTH-1:0];
               wr_cnt_d = wr_cnt_q + ONE;
               if (wr_cnt_q == n_last) begin
                  state_d  = S_WAIT_CALC;
                  loaded_d = 1'b1;
               end
            end
         end
         S_WAIT_CALC: begin
            if (bus.i_CALC_END) begin
               state_d  = S_UNLOAD;
               rd_cnt_d = '0;
            end
         end
         S_UNLOAD: begin
            pop = head_vld && bus.i_ARREADY;
            // Slots still committed after this cycle; counting the pop keeps
            // reads back-to-back when the consumer is always ready.
            occ_after = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
            rd_en     = (rd_cnt_q < n_q) && (occ_after < 2'd2);
            if (rd_en) begin
               rd_cnt_d   = rd_cnt_q + ONE;
               inflight_d = 1'b1;
            end
            if (pop) begin
               out_cnt_d = out_cnt_q + ONE;
               if (out_cnt_q == n_last) frame_done = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (push) fifo_wp_d = ~fifo_wp_q;
      if (pop)  fifo_rp_d = ~fifo_rp_q;
      fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

      if (frame_done) begin
         state_d    = S_IDLE;
         wr_cnt_d   = '0;
         rd_cnt_d   = '0;
         out_cnt_d  = '0;
         inflight_d = 1'b0;
         fifo_cnt_d = 2'd0;
         fifo_wp_d  = 1'b0;
         fifo_rp_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         out_cnt_q  <= '0;
         loaded_q   <= 1'b0;
         inflight_q <= 1'b0;
         fifo_cnt_q <= 2'd0;
         fifo_wp_q  <= 1'b0;
         fifo_rp_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         out_cnt_q  <= out_cnt_d;
         loaded_q   <= loaded_d;
         inflight_q <= inflight_d;
         fifo_cnt_q <= fifo_cnt_d;
         fifo_wp_q  <= fifo_wp_d;
         fifo_rp_q  <= fifo_rp_d;
      end
   end

   // Result storage carries no reset; occupancy is tracked by fifo_cnt_q.
   always_ff @(posedge i_clk) begin
      if (push) fifo_mem_q[fifo_wp_q] <= bus.i_DATA_FROM_RAM;
   end

   assign bus.o_AWREADY          = awready;
   assign bus.o_WRITE_ram        = wr_en;
   assign bus.o_SAMPLE_ram       = wr_en ? bus.i_AWDATA : {SAMPLE_WIDTH{1'b0}};
   assign bus.o_READ_ram         = rd_en;
   assign bus.o_SAMPLE_INDEX_ram = wr_en ? wr_idx : (rd_en ? rd_addr : '0);
   assign bus.o_DATA_LOADED      = loaded_q;
   assign bus.o_ARVALID          = head_vld;
   assign bus.o_ARDATA           = head_vld ? fifo_mem_q[fifo_rp_q] : '0;
   assign bus.o_ARLAST           = head_vld && (out_cnt_q == n_last);

endmodule
